tile_addr_gen: RTL and testbench

Tile address generator: the responder side of the tile start/done handshake driven by the matmul tile controller. It accepts one tile descriptor per `start_tile` pulse and walks the tile's A block (eTM×eTK), then its B block (eTK×eTN), then its C block (eTM×eTN). It emits one element address per accepted beat on a valid/ready stream toward the scratchpad/DMA port, then pulses `tile_done`.

---
 rtl/tile_agu_pkg.sv | 30 +++
 rtl/tile_addr_gen_walker.sv | 100 ++++++++++
 rtl/tile_addr_gen.sv | 202 ++++++++++++++++++++
 tb/tb_tile_addr_gen.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_agu_pkg.sv
// Shared types for the tile address generator.
// Holds the phase enum and the addr_sel operand encodings.
package tile_agu_pkg;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_LOAD_C,
    PH_LOAD_A,
    PH_LOAD_B,
    PH_STORE_C
  } phase_e;

  localparam logic [1:0] SEL_A   = 2'd0;
  localparam logic [1:0] SEL_B   = 2'd1;
  localparam logic [1:0] SEL_C   = 2'd2;
  localparam logic [1:0] SEL_CRD = 2'd3;

  function automatic logic [1:0] phase_sel(phase_e p);
    logic [1:0] s;
    s = SEL_A;
    case (p)
      PH_LOAD_C:  s = SEL_CRD;
      PH_LOAD_B:  s = SEL_B;
      PH_STORE_C: s = SEL_C;
      default:    s = SEL_A;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tile_addr_gen_walker.sv
// tile_rect_walker: row-major 2-D walker, addr = base + row*pitch + col.
// Ports: clr_i/load_i/adv_i control, base/rows/cols/pitch load, addr_o/last_o.
module tile_rect_walker #(
  parameter int AW = 32,
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic          adv_i,
  input  logic [AW-1:0] base_i,
  input  logic [IW-1:0] rows_i,
  input  logic [IW-1:0] cols_i,
  input  logic [IW-1:0] pitch_i,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);

  logic [IW-1:0] row_q, row_d;
  logic [IW-1:0] col_q, col_d;
  logic [IW-1:0] rows_q, rows_d;
  logic [IW-1:0] cols_q, cols_d;
  logic [IW-1:0] pitch_q, pitch_d;
  logic [AW-1:0] rbase_q, rbase_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          last_q, last_d;
  logic [AW-1:0] rnext;

  assign rnext = rbase_q + AW'(pitch_q);

  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    pitch_d = pitch_q;
    rbase_d = rbase_q;
    addr_d  = addr_q;
    last_d  = last_q;
    if (clr_i) begin
      row_d   = '0;
      col_d   = '0;
      rows_d  = '0;
      cols_d  = '0;
      pitch_d = '0;
      rbase_d = '0;
      addr_d  = '0;
      last_d  = 1'b0;
    end else if (load_i) begin
      row_d   = '0;
      col_d   = '0;
      rows_d  = rows_i;
      cols_d  = cols_i;
      pitch_d = pitch_i;
      rbase_d = base_i;
      addr_d  = base_i;
      last_d  = (rows_i == IW'(1)) &&
                (cols_i == IW'(1));
    end else if (adv_i) begin
      if (col_q == cols_q - IW'(1)) begin
        col_d   = '0;
        row_d   = row_q + IW'(1);
        rbase_d = rnext;
        addr_d  = rnext;
      end else begin
        col_d  = col_q + IW'(1);
        addr_d = addr_q + AW'(1);
      end
      last_d = (row_d == rows_q - IW'(1)) &&
               (col_d == cols_q - IW'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q   <= '0;
      col_q   <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      pitch_q <= '0;
      rbase_q <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      pitch_q <= pitch_d;
      rbase_q <= rbase_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = last_q;

endmodule

// File: rtl/tile_addr_gen.sv
// Tile AGU: walks A, B, then C blocks of a tile on a valid/ready stream.
// Ports: start/descriptor in, tile_ready/done out, addr stream out.
// TILE_AGU_CLOAD_EN adds c_accum and a C read-back phase before A.
module tile_addr_gen
  import tile_agu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_tile,
  input  logic [ADDR_WIDTH-1:0] baseA_tile,
  input  logic [ADDR_WIDTH-1:0] baseB_tile,
  input  logic [ADDR_WIDTH-1:0] baseC_tile,
  input  logic [IDX_WIDTH-1:0]  eTM,
  input  logic [IDX_WIDTH-1:0]  eTN,
  input  logic [IDX_WIDTH-1:0]  eTK,
  input  logic [IDX_WIDTH-1:0]  K,
  input  logic [IDX_WIDTH-1:0]  N,
  output logic                  tile_ready,
  output logic                  tile_done,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [1:0]            addr_sel,
  output logic                  addr_last,
  output logic                  addr_valid,
  input  logic                  addr_ready
`ifdef TILE_AGU_CLOAD_EN
  ,
  input  logic                  c_accum
`endif
);

  localparam int AW = ADDR_WIDTH;
  localparam int IW = IDX_WIDTH;

  phase_e state_q, state_d;

  logic [AW-1:0] ba_q, bb_q, bc_q;
  logic [IW-1:0] tm_q, tn_q, tk_q;
  logic [IW-1:0] k_q, n_q;

  logic          valid_q, valid_d;
  logic [1:0]    sel_q, sel_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;

  logic          idle, accept, zero;
  logic          hs, ph_end, cload_req;
  logic          w_clr, w_load, w_adv, w_last;
  logic [AW-1:0] w_base;
  logic [IW-1:0] w_rows, w_cols, w_pitch;

  logic [AW-1:0] v_ba, v_bc;
  logic [IW-1:0] v_tm, v_tn, v_tk;
  logic [IW-1:0] v_k, v_n;

`ifdef TILE_AGU_CLOAD_EN
  assign cload_req = c_accum;
`else
  assign cload_req = 1'b0;
`endif

  assign idle   = (state_q == PH_IDLE);
  assign accept = idle && start_tile;
  assign zero   = (eTM == '0) || (eTN == '0) ||
                  (eTK == '0);
  assign hs     = valid_q && addr_ready;
  assign ph_end = hs && w_last;

  // The first phase loads in the latch cycle itself,
  // so it must see the raw inputs, not the latches.
  assign v_ba = idle ? baseA_tile : ba_q;
  assign v_bc = idle ? baseC_tile : bc_q;
  assign v_tm = idle ? eTM : tm_q;
  assign v_tn = idle ? eTN : tn_q;
  assign v_tk = idle ? eTK : tk_q;
  assign v_k  = idle ? K : k_q;
  assign v_n  = idle ? N : n_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= PH_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PH_IDLE:
        if (start_tile && !zero)
          state_d = cload_req ? PH_LOAD_C
                              : PH_LOAD_A;
      PH_LOAD_C:
        if (ph_end) state_d = PH_LOAD_A;
      PH_LOAD_A:
        if (ph_end) state_d = PH_LOAD_B;
      PH_LOAD_B:
        if (ph_end) state_d = PH_STORE_C;
      PH_STORE_C:
        if (ph_end) state_d = PH_IDLE;
      default:
        state_d = PH_IDLE;
    endcase
  end

  always_comb begin
    w_load  = (accept && !zero) ||
              (ph_end && state_d != PH_IDLE);
    w_clr   = ph_end && (state_d == PH_IDLE);
    w_adv   = hs && !w_last;
    w_base  = '0;
    w_rows  = '0;
    w_cols  = '0;
    w_pitch = '0;
    case (state_d)
      PH_LOAD_C, PH_STORE_C: begin
        w_base  = v_bc;
        w_rows  = v_tm;
        w_cols  = v_tn;
        w_pitch = v_n;
      end
      PH_LOAD_A: begin
        w_base  = v_ba;
        w_rows  = v_tm;
        w_cols  = v_tk;
        w_pitch = v_k;
      end
      PH_LOAD_B: begin
        w_base  = bb_q;
        w_rows  = v_tk;
        w_cols  = v_tn;
        w_pitch = v_n;
      end
      default: ;
    endcase
    valid_d = (state_d != PH_IDLE);
    ready_d = (state_d == PH_IDLE);
    sel_d   = phase_sel(state_d);
    done_d  = (state_q == PH_STORE_C && ph_end) ||
              (accept && zero);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      sel_q   <= SEL_A;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      valid_q <= valid_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ba_q <= '0;
      bb_q <= '0;
      bc_q <= '0;
      tm_q <= '0;
      tn_q <= '0;
      tk_q <= '0;
      k_q  <= '0;
      n_q  <= '0;
    end else if (accept) begin
      ba_q <= baseA_tile;
      bb_q <= baseB_tile;
      bc_q <= baseC_tile;
      tm_q <= eTM;
      tn_q <= eTN;
      tk_q <= eTK;
      k_q  <= K;
      n_q  <= N;
    end
  end

  tile_rect_walker #(
    .AW(AW),
    .IW(IW)
  ) u_walk (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (w_clr),
    .load_i (w_load),
    .adv_i  (w_adv),
    .base_i (w_base),
    .rows_i (w_rows),
    .cols_i (w_cols),
    .pitch_i(w_pitch),
    .addr_o (addr),
    .last_o (w_last)
  );

  assign addr_last  = w_last;
  assign addr_valid = valid_q;
  assign addr_sel   = sel_q;
  assign tile_done  = done_q;
  assign tile_ready = ready_q;

endmodule

// File: tb/tb_tile_addr_gen.sv
// Directed bench for tile_addr_gen.
// Covers full tile, stalls, zero dims, back-to-back, wrap, reset.
module tb_tile_addr_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_tile;
  logic [31:0] baseA_tile, baseB_tile, baseC_tile;
  logic [7:0]  eTM, eTN, eTK, K, N;
  logic        tile_ready, tile_done;
  logic [31:0] addr;
  logic [1:0]  addr_sel;
  logic        addr_last, addr_valid;
  logic        addr_ready;
  logic        c_accum;

  always #5 clk = ~clk;

  tile_addr_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start_tile(start_tile),
    .baseA_tile(baseA_tile),
    .baseB_tile(baseB_tile),
    .baseC_tile(baseC_tile),
    .eTM       (eTM),
    .eTN       (eTN),
    .eTK       (eTK),
    .K         (K),
    .N         (N),
    .tile_ready(tile_ready),
    .tile_done (tile_done),
    .addr      (addr),
    .addr_sel  (addr_sel),
    .addr_last (addr_last),
    .addr_valid(addr_valid),
    .addr_ready(addr_ready)
`ifdef TILE_AGU_CLOAD_EN
    ,
    .c_accum   (c_accum)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [34:0] got[$];
  logic [34:0] exp_q[$];
  int          viol;
  logic        rdy1, vld1, done_rdy, done_vld;

  logic [31:0] t1a[16] = '{
    32'h100, 32'h101, 32'h102,
    32'h108, 32'h109, 32'h10A,
    32'h200, 32'h201, 32'h204,
    32'h205, 32'h208, 32'h209,
    32'h300, 32'h301, 32'h304,
    32'h305};

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] req);
    n_chk++;
    if (obs !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, req);
    end
  endtask

  function automatic logic [34:0] bt(
    input logic [31:0] a,
    input logic [1:0]  s,
    input logic        l);
    return {l, s, a};
  endfunction

  task automatic set_desc(
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] c, input logic [7:0] tm,
    input logic [7:0] tn, input logic [7:0] tk,
    input logic [7:0] kk, input logic [7:0] nn);
    baseA_tile = a;
    baseB_tile = b;
    baseC_tile = c;
    eTM = tm;
    eTN = tn;
    eTK = tk;
    K   = kk;
    N   = nn;
  endtask

  task automatic exp_tile1(input bit crd);
    logic [1:0] s;
    exp_q.delete();
    if (crd) begin
      exp_q.push_back(bt(32'h300, 2'd3, 1'b0));
      exp_q.push_back(bt(32'h301, 2'd3, 1'b0));
      exp_q.push_back(bt(32'h304, 2'd3, 1'b0));
      exp_q.push_back(bt(32'h305, 2'd3, 1'b1));
    end
    for (int i = 0; i < 16; i++) begin
      s = (i < 6) ? 2'd0 : (i < 12) ? 2'd1 : 2'd2;
      exp_q.push_back(bt(t1a[i], s,
        (i == 5) || (i == 11) || (i == 15)));
    end
  endtask

  task automatic cmp_beats(input string tag);
    check({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got.size())
        check($sformatf("%s_beat%0d", tag, i),
              got[i], exp_q[i]);
  endtask

  task automatic run_tile(input bit pre, input bit rnd,
                          input bit chain, input int poke,
                          output int done_cyc);
    logic [34:0] pv;
    logic        pstall;
    got.delete();
    viol = 0;
    done_cyc = -1;
    pstall = 1'b0;
    pv = '0;
    if (!pre) begin
      @(negedge clk);
      start_tile = 1'b1;
    end
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      start_tile = (c == poke);
      if (c == poke)
        set_desc(32'hDEAD0000, 32'hBEEF0000,
                 32'hCAFE0000, 8'd9, 8'd9, 8'd9,
                 8'd7, 8'd7);
      addr_ready = rnd ? 1'($urandom_range(0, 1))
                       : 1'b1;
      if (c == 1) begin
        rdy1 = tile_ready;
        vld1 = addr_valid;
      end
      if (pstall && (!addr_valid ||
          {addr_last, addr_sel, addr} != pv))
        viol++;
      pstall = addr_valid && !addr_ready;
      pv = {addr_last, addr_sel, addr};
      if (addr_valid && addr_ready)
        got.push_back(pv);
      if (tile_done) begin
        done_cyc = c;
        done_rdy = tile_ready;
        done_vld = addr_valid;
        if (chain) start_tile = 1'b1;
        break;
      end
    end
    check("done_seen", done_cyc >= 0, 1);
    addr_ready = 1'b1;
  endtask

  int d;
  int seen_b;
  int dn;

  initial begin
    rst = 1'b1;
    start_tile = 1'b0;
    addr_ready = 1'b1;
    c_accum = 1'b0;
    set_desc(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_ready", tile_ready, 1);
    check("rst_done", tile_done, 0);
    check("rst_valid", addr_valid, 0);
    check("rst_addr", addr, 0);
    check("rst_sel", addr_sel, 0);
    check("rst_last", addr_last, 0);
    rst = 1'b0;
    @(negedge clk);

    // full tile, ready tied high
    set_desc(32'h100, 32'h200, 32'h300,
             8'd2, 8'd2, 8'd3, 8'd8, 8'd4);
    run_tile(0, 0, 0, 0, d);
    check("t1_ready_low", rdy1, 0);
    check("t1_first_valid", vld1, 1);
    check("t1_latency", d, 17);
    check("t1_done_ready", done_rdy, 1);
    check("t1_done_valid", done_vld, 0);
    exp_tile1(0);
    cmp_beats("t1");

    // random stalls, mid-tile start with junk desc
    set_desc(32'h100, 32'h200, 32'h300,
             8'd2, 8'd2, 8'd3, 8'd8, 8'd4);
    run_tile(0, 1, 0, 4, d);
    check("t2_stall_stable", viol, 0);
    cmp_beats("t2");

    // zero dimension
    set_desc(32'h100, 32'h200, 32'h300,
             8'd2, 8'd2, 8'd0, 8'd8, 8'd4);
    run_tile(0, 0, 0, 0, d);
    check("t3_latency", d, 1);
    check("t3_ready", rdy1, 1);
    check("t3_no_valid", vld1, 0);
    check("t3_beats", got.size(), 0);

    // back-to-back: 1x1x1 tile then wrap tile
    set_desc(32'h40, 32'h50, 32'h60,
             8'd1, 8'd1, 8'd1, 8'd1, 8'd1);
    run_tile(0, 0, 1, 0, d);
    check("t4_latency", d, 4);
    exp_q.delete();
    exp_q.push_back(bt(32'h40, 2'd0, 1'b1));
    exp_q.push_back(bt(32'h50, 2'd1, 1'b1));
    exp_q.push_back(bt(32'h60, 2'd2, 1'b1));
    cmp_beats("t4");
    set_desc(32'h10, 32'h20, 32'hFFFF_FFFE,
             8'd1, 8'd3, 8'd1, 8'd1, 8'd4);
    run_tile(1, 0, 0, 0, d);
    check("t5_b2b_valid", vld1, 1);
    check("t5_b2b_ready", rdy1, 0);
    check("t5_latency", d, 8);
    exp_q.delete();
    exp_q.push_back(bt(32'h10, 2'd0, 1'b1));
    exp_q.push_back(bt(32'h20, 2'd1, 1'b0));
    exp_q.push_back(bt(32'h21, 2'd1, 1'b0));
    exp_q.push_back(bt(32'h22, 2'd1, 1'b1));
    exp_q.push_back(bt(32'hFFFF_FFFE, 2'd2, 1'b0));
    exp_q.push_back(bt(32'hFFFF_FFFF, 2'd2, 1'b0));
    exp_q.push_back(bt(32'h0, 2'd2, 1'b1));
    cmp_beats("t5");

    // reset during LOAD_B
    set_desc(32'h100, 32'h200, 32'h300,
             8'd2, 8'd2, 8'd3, 8'd8, 8'd4);
    @(negedge clk);
    start_tile = 1'b1;
    @(negedge clk);
    start_tile = 1'b0;
    seen_b = 0;
    for (int i = 0; i < 20; i++) begin
      if (addr_valid && addr_sel == 2'd1) begin
        seen_b = 1;
        break;
      end
      @(negedge clk);
    end
    check("t6_reached_b", seen_b, 1);
    rst = 1'b1;
    #1;
    check("t6_valid", addr_valid, 0);
    check("t6_ready", tile_ready, 1);
    check("t6_addr", addr, 0);
    check("t6_sel", addr_sel, 0);
    check("t6_last", addr_last, 0);
    check("t6_done", tile_done, 0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (tile_done || addr_valid) dn++;
    end
    check("t6_quiet_after", dn, 0);

`ifdef TILE_AGU_CLOAD_EN
    c_accum = 1'b1;
    set_desc(32'h100, 32'h200, 32'h300,
             8'd2, 8'd2, 8'd3, 8'd8, 8'd4);
    run_tile(0, 0, 0, 0, d);
    c_accum = 1'b0;
    check("t7_latency", d, 21);
    exp_tile1(1);
    cmp_beats("t7");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
